// File: rtl/osd_pkg.sv
// osd_pkg: shared definitions for the OSD overlay blend path.
//   - RGB565 field widths / bit positions
//   - named colour constants
//   - pipeline latency and alpha ceiling
//   - sat_alpha(): clamps the 9-bit video weight to 0..ALPHA_MAX
package osd_pkg;

  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int R_LSB = 11;
  localparam int G_LSB = 5;
  localparam int B_LSB = 0;

  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] YELLOW = 16'hFFE0;

  localparam int OSD_LATENCY = 3;
  localparam int ALPHA_MAX   = 256;

  function automatic logic [8:0] sat_alpha(input logic [8:0] a);
    return (a > 9'(ALPHA_MAX)) ? 9'(ALPHA_MAX) : a;
  endfunction

endpackage

// File: rtl/osd_alpha_mix.sv
// osd_alpha_mix: one colour channel of the overlay/video blend.
//   out = ((ALPHA_MAX - a) * ovl + a * vid) >> 8, truncating.
// Ports:
//   i_ovl   [CW-1:0] overlay channel value
//   i_vid   [CW-1:0] live video channel value
//   i_alpha [8:0]    video weight, already clamped to 0..ALPHA_MAX
//   o_mix   [CW-1:0] blended channel
// Purely combinational; the caller registers the result.
module osd_alpha_mix
  import osd_pkg::*;
#(
  parameter int CW = 5
) (
  input  logic [CW-1:0] i_ovl,
  input  logic [CW-1:0] i_vid,
  input  logic [8:0]    i_alpha,
  output logic [CW-1:0] o_mix
);

  // CW+9 bits holds 256 * (2**CW - 1) with room to spare, so no overflow.
  logic [CW+8:0] w_ovl_term;
  logic [CW+8:0] w_vid_term;
  logic [CW+8:0] w_sum;

  always_comb begin
    w_ovl_term = (CW+9)'(9'(ALPHA_MAX) - i_alpha) * (CW+9)'(i_ovl);
    w_vid_term = (CW+9)'(i_alpha) * (CW+9)'(i_vid);
    w_sum      = w_ovl_term + w_vid_term;
    o_mix      = CW'(w_sum >> 8);
  end

endmodule

// File: rtl/osd_overlay_blend.sv
// osd_overlay_blend: 3-clock pipelined text-window overlay for the RGB565
// pixel stream, with glyphs from an external synchronous 1-bit glyph ROM,
// optional horizontal scrolling, and per-channel alpha blending.
// Ports:
//   clk, rst_n            pixel clock, async active-low reset
//   frame_start           pulse before first pixel; latches all cfg_* / scroll_en
//   in_de/in_x/in_y/in_data   input pixel stream
//   cfg_*                 window, colours, alpha (video weight), enable
//   scroll_en             scroll enable (shadowed)
//   rom_addr / rom_q      glyph column address (registered) / column data
//   out_de / out_data     output pixel stream, in_de delayed by 3 clocks
// Stream handshake: no back-pressure; in_de qualifies a pixel each clock and
// out_de is exactly in_de delayed by three clocks.
module osd_overlay_blend
  import osd_pkg::*;
#(
  parameter int XW          = 11,
  parameter int ROM_AW      = 11,
  parameter int ROM_DW      = 32,
  parameter int SCROLL_LEN  = 1424,
  parameter int SCROLL_STEP = 1,
  parameter int SCROLL_DIV  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              in_de,
  input  logic [XW-1:0]     in_x,
  input  logic [XW-1:0]     in_y,
  input  logic [15:0]       in_data,
  input  logic              cfg_en,
  input  logic [XW-1:0]     cfg_x0,
  input  logic [XW-1:0]     cfg_y0,
  input  logic [XW-1:0]     cfg_w,
  input  logic [15:0]       cfg_fg,
  input  logic [15:0]       cfg_bg,
  input  logic              cfg_bg_en,
  input  logic [8:0]        cfg_alpha,
  input  logic              scroll_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [ROM_DW-1:0] rom_q,
  output logic              out_de,
  output logic [15:0]       out_data
);

  localparam int RW = (ROM_DW > 1) ? $clog2(ROM_DW) : 1;
  localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int CW = XW + 2;

  // Shadow configuration, frame-synchronous.
  logic              r_sh_en;
  logic [XW-1:0]     r_sh_x0;
  logic [XW-1:0]     r_sh_y0;
  logic [XW-1:0]     r_sh_w;
  logic [15:0]       r_sh_fg;
  logic [15:0]       r_sh_bg;
  logic              r_sh_bg_en;
  logic [8:0]        r_sh_alpha;
  logic              r_sh_scroll_en;
  logic [ROM_AW-1:0] r_offset;
  logic [FW-1:0]     r_frame_cnt;

  logic [ROM_AW:0]   w_off_inc;
  logic [ROM_AW-1:0] w_off_next;

  always_comb begin
    w_off_inc = {1'b0, r_offset} + (ROM_AW+1)'(SCROLL_STEP);
    if (w_off_inc >= (ROM_AW+1)'(SCROLL_LEN))
      w_off_next = ROM_AW'(w_off_inc - (ROM_AW+1)'(SCROLL_LEN));
    else
      w_off_next = ROM_AW'(w_off_inc);
  end

  // The scroll decision uses the shadow scroll_en held before this pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_en        <= 1'b0;
      r_sh_x0        <= '0;
      r_sh_y0        <= '0;
      r_sh_w         <= '0;
      r_sh_fg        <= '0;
      r_sh_bg        <= '0;
      r_sh_bg_en     <= 1'b0;
      r_sh_alpha     <= '0;
      r_sh_scroll_en <= 1'b0;
      r_offset       <= '0;
      r_frame_cnt    <= '0;
    end else if (frame_start) begin
      r_sh_en        <= cfg_en;
      r_sh_x0        <= cfg_x0;
      r_sh_y0        <= cfg_y0;
      r_sh_w         <= cfg_w;
      r_sh_fg        <= cfg_fg;
      r_sh_bg        <= cfg_bg;
      r_sh_bg_en     <= cfg_bg_en;
      r_sh_alpha     <= sat_alpha(cfg_alpha);
      r_sh_scroll_en <= scroll_en;
      if (r_sh_scroll_en) begin
        if (r_frame_cnt == FW'(SCROLL_DIV - 1)) begin
          r_frame_cnt <= '0;
          r_offset    <= w_off_next;
        end else begin
          r_frame_cnt <= r_frame_cnt + FW'(1);
        end
      end
    end
  end

  // Stage 1: window test and glyph column. One extra bit on the x/y ends
  // keeps x0+w from wrapping at the display edge.
  logic [XW:0]   w_x_end;
  logic [XW:0]   w_y_end;
  logic          w_win;
  logic [CW-1:0] w_col_raw;
  logic [CW-1:0] w_col;
  logic [XW-1:0] w_dy;

  always_comb begin
    w_x_end   = {1'b0, r_sh_x0} + {1'b0, r_sh_w};
    w_y_end   = {1'b0, r_sh_y0} + (XW+1)'(ROM_DW);
    w_win     = r_sh_en & in_de
              & ({1'b0, in_x} >= {1'b0, r_sh_x0}) & ({1'b0, in_x} < w_x_end)
              & ({1'b0, in_y} >= {1'b0, r_sh_y0}) & ({1'b0, in_y} < w_y_end);
    // Inside the window col < 2*SCROLL_LEN, so one subtract always suffices.
    w_col_raw = CW'(in_x) - CW'(r_sh_x0) + CW'(r_offset);
    w_col     = (w_col_raw >= CW'(SCROLL_LEN)) ? w_col_raw - CW'(SCROLL_LEN) : w_col_raw;
    w_dy      = in_y - r_sh_y0;
  end

  logic              r_de1, r_win1, r_de2, r_win2;
  logic [RW-1:0]     r_row1, r_row2;
  logic [15:0]       r_vid1, r_vid2;
  logic [ROM_AW-1:0] r_rom_addr;

  // Stage 2 only delays the pixel context while the ROM registers the
  // column addressed in stage 1; rom_q is valid alongside these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de1      <= 1'b0;
      r_win1     <= 1'b0;
      r_row1     <= '0;
      r_vid1     <= '0;
      r_rom_addr <= '0;
      r_de2      <= 1'b0;
      r_win2     <= 1'b0;
      r_row2     <= '0;
      r_vid2     <= '0;
    end else begin
      r_de1      <= in_de;
      r_win1     <= w_win;
      r_row1     <= RW'(w_dy);
      r_vid1     <= in_data;
      r_rom_addr <= ROM_AW'(w_col);
      r_de2      <= r_de1;
      r_win2     <= r_win1;
      r_row2     <= r_row1;
      r_vid2     <= r_vid1;
    end
  end

  // Stage 3: glyph bit select, colour choice, blend, output register.
  logic        w_bit;
  logic [15:0] w_ovl;
  logic        w_use;
  logic [15:0] w_mix;

  always_comb begin
    w_bit = rom_q[RW'(ROM_DW - 1) - r_row2];
    w_ovl = w_bit ? r_sh_fg : r_sh_bg;
    w_use = r_win2 & (w_bit | r_sh_bg_en);
  end

  osd_alpha_mix #(.CW(R_W)) u_mix_r (
    .i_ovl   (w_ovl[R_LSB +: R_W]),
    .i_vid   (r_vid2[R_LSB +: R_W]),
    .i_alpha (r_sh_alpha),
    .o_mix   (w_mix[R_LSB +: R_W])
  );
  osd_alpha_mix #(.CW(G_W)) u_mix_g (
    .i_ovl   (w_ovl[G_LSB +: G_W]),
    .i_vid   (r_vid2[G_LSB +: G_W]),
    .i_alpha (r_sh_alpha),
    .o_mix   (w_mix[G_LSB +: G_W])
  );
  osd_alpha_mix #(.CW(B_W)) u_mix_b (
    .i_ovl   (w_ovl[B_LSB +: B_W]),
    .i_vid   (r_vid2[B_LSB +: B_W]),
    .i_alpha (r_sh_alpha),
    .o_mix   (w_mix[B_LSB +: B_W])
  );

  logic        r_out_de;
  logic [15:0] r_out_data;

  // Pixels outside the overlay bypass the blend so video is bit-exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_de   <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_out_de   <= r_de2;
      r_out_data <= !r_de2 ? 16'h0000 : (w_use ? w_mix : r_vid2);
    end
  end

  assign rom_addr = r_rom_addr;
  assign out_de   = r_out_de;
  assign out_data = r_out_data;

endmodule

// File: tb/tb_osd_overlay_blend.sv
// Self-checking bench for osd_overlay_blend with a behavioural pixel model,
// a synchronous glyph ROM model, and directed plus random scenarios.
`timescale 1ns/1ps
module tb_osd_overlay_blend;
  import osd_pkg::*;

  localparam int ROM_DW      = 32;
  localparam int SCROLL_LEN  = 1424;
  localparam int SCROLL_STEP = 1;
  localparam int SCROLL_DIV  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        in_de = 1'b0;
  logic [10:0] in_x = '0, in_y = '0;
  logic [15:0] in_data = '0;
  logic        cfg_en = 1'b0;
  logic [10:0] cfg_x0 = '0, cfg_y0 = '0, cfg_w = '0;
  logic [15:0] cfg_fg = '0, cfg_bg = '0;
  logic        cfg_bg_en = 1'b0;
  logic [8:0]  cfg_alpha = '0;
  logic        scroll_en = 1'b0;
  logic [10:0] rom_addr;
  logic [31:0] rom_q = '0;
  logic        out_de;
  logic [15:0] out_data;

  logic [31:0] rom_mem [0:2047];
  logic [16:0] exp_q[$];
  int n_err = 0;
  int n_checks = 0;

  // Model shadow state
  int m_en = 0, m_x0 = 0, m_y0 = 0, m_w = 0, m_fg = 0, m_bg = 0, m_bg_en = 0, m_alpha = 0;
  int m_scroll_en = 0, m_counted = 0;

  osd_overlay_blend dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .in_de(in_de), .in_x(in_x), .in_y(in_y), .in_data(in_data),
    .cfg_en(cfg_en), .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_w(cfg_w),
    .cfg_fg(cfg_fg), .cfg_bg(cfg_bg), .cfg_bg_en(cfg_bg_en), .cfg_alpha(cfg_alpha),
    .scroll_en(scroll_en), .rom_addr(rom_addr), .rom_q(rom_q),
    .out_de(out_de), .out_data(out_data)
  );

  // Clock / reset block and glyph ROM model
  always #5 clk = ~clk;
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  function automatic int m_offset();
    return ((m_counted / SCROLL_DIV) * SCROLL_STEP) % SCROLL_LEN;
  endfunction

  function automatic int blend_ch(input int ovl, input int vid, input int a);
    return ((256 - a) * ovl + a * vid) / 256;
  endfunction

  // Reference pixel: {de, data} three clocks after the input.
  function automatic logic [16:0] ref_px(input logic de, input int x, input int y, input logic [15:0] vid);
    int col, a, r, g, b;
    logic [15:0] ovl;
    logic [31:0] word;
    logic bitv;
    if (!de) return 17'h0;
    if (m_en == 0 || x < m_x0 || x >= m_x0 + m_w || y < m_y0 || y >= m_y0 + ROM_DW)
      return {1'b1, vid};
    col  = (x - m_x0 + m_offset()) % SCROLL_LEN;
    word = rom_mem[col];
    bitv = word[ROM_DW - 1 - (y - m_y0)];
    if (!bitv && m_bg_en == 0) return {1'b1, vid};
    ovl = bitv ? 16'(m_fg) : 16'(m_bg);
    a   = (m_alpha > 256) ? 256 : m_alpha;
    r   = blend_ch(int'(ovl[15:11]), int'(vid[15:11]), a);
    g   = blend_ch(int'(ovl[10:5]),  int'(vid[10:5]),  a);
    b   = blend_ch(int'(ovl[4:0]),   int'(vid[4:0]),   a);
    return {1'b1, 5'(r), 6'(g), 5'(b)};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic de, input logic [10:0] x, input logic [10:0] y, input logic [15:0] d);
    in_de = de; in_x = x; in_y = y; in_data = d;
    tick();
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1; in_de = 1'b0;
    tick();
    frame_start = 1'b0;
    if (m_scroll_en != 0) m_counted++;
    m_en = int'(cfg_en); m_x0 = int'(cfg_x0); m_y0 = int'(cfg_y0); m_w = int'(cfg_w);
    m_fg = int'(cfg_fg); m_bg = int'(cfg_bg); m_bg_en = int'(cfg_bg_en);
    m_alpha = int'(cfg_alpha); m_scroll_en = int'(scroll_en);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++;
    if (out_de !== 1'b0) begin n_err++; $display("FAIL reset_out_de: got %0b want 0", out_de); end
    n_checks++;
    if (out_data !== 16'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    n_checks++;
    if (rom_addr !== 11'h0) begin n_err++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (out_de !== 1'b0) begin n_err++; $display("FAIL reset_release_de: got %0b want 0", out_de); end
  endtask

  task automatic test_passthrough();
    logic de; logic [16:0] e;
    cfg_en = 1'b0; cfg_x0 = 11'd0; cfg_y0 = 11'd0; cfg_w = 11'd1000;
    cfg_bg_en = 1'b1; cfg_alpha = 9'd0;
    frame_pulse();
    exp_q.delete();
    for (int i = 0; i < 256 + 3; i++) begin
      de = (i < 256) && (i % 17 != 5);
      exp_q.push_back(de ? {1'b1, 16'(i)} : 17'h0);
      drive(de, 11'(i), 11'(i % 32), 16'(i));
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front(); n_checks++;
        if ({out_de, out_data} !== e) begin
          n_err++;
          $display("FAIL passthrough: got de=%0b data=%h want de=%0b data=%h", out_de, out_data, e[16], e[15:0]);
        end
      end
    end
  endtask

  task automatic test_opaque_glyph();
    int xs[7] = '{128, 129, 127, 128, 128, 511, 512};
    int ys[7] = '{100, 100, 100, 131, 132, 100, 100};
    logic [15:0] vids[7] = '{16'h1234, 16'h2345, 16'h5555, 16'h0F0F, 16'hABCD, 16'h4321, 16'h6666};
    logic [15:0] want[7] = '{BLUE, WHITE, 16'h5555, WHITE, 16'hABCD, BLUE, 16'h6666};
    logic [16:0] e;
    rom_mem[0] = 32'h8000_0000; rom_mem[1] = 32'h7FFF_FFFF; rom_mem[383] = 32'h8000_0000;
    cfg_en = 1'b1; cfg_x0 = 11'd128; cfg_y0 = 11'd100; cfg_w = 11'd384;
    cfg_fg = BLUE; cfg_bg = WHITE; cfg_bg_en = 1'b1; cfg_alpha = 9'd0;
    frame_pulse();
    exp_q.delete();
    for (int i = 0; i < 7 + 3; i++) begin
      if (i < 7) begin
        exp_q.push_back({1'b1, want[i]});
        drive(1'b1, 11'(xs[i]), 11'(ys[i]), vids[i]);
      end else begin
        exp_q.push_back(17'h0);
        drive(1'b0, 11'd0, 11'd0, 16'h0);
      end
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front(); n_checks++;
        if ({out_de, out_data} !== e) begin
          n_err++;
          $display("FAIL opaque_glyph: got de=%0b data=%h want de=%0b data=%h", out_de, out_data, e[16], e[15:0]);
        end
      end
    end
  endtask

  task automatic test_blend();
    logic [16:0] e;
    logic [8:0] alphas[2] = '{9'd128, 9'd300};
    logic [15:0] want[2] = '{16'h7BE0, GREEN};
    cfg_en = 1'b1; cfg_x0 = 11'd0; cfg_y0 = 11'd0; cfg_w = 11'd16;
    cfg_fg = RED; cfg_bg = RED; cfg_bg_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cfg_alpha = alphas[k];
      frame_pulse();
      exp_q.delete();
      for (int i = 0; i < 18 + 3; i++) begin
        if (i < 18) begin
          exp_q.push_back({1'b1, (i < 16) ? want[k] : GREEN});
          drive(1'b1, 11'(i), 11'(i % 4), GREEN);
        end else begin
          exp_q.push_back(17'h0);
          drive(1'b0, 11'd0, 11'd0, 16'h0);
        end
        if (exp_q.size() == 3) begin
          e = exp_q.pop_front(); n_checks++;
          if ({out_de, out_data} !== e) begin
            n_err++;
            $display("FAIL blend a=%0d: got de=%0b data=%h want de=%0b data=%h", alphas[k], out_de, out_data, e[16], e[15:0]);
          end
        end
      end
    end
  endtask

  task automatic test_transparent();
    logic [16:0] e; logic [15:0] d;
    for (int c = 0; c < 64; c++) rom_mem[c] = 32'h0;
    cfg_en = 1'b1; cfg_x0 = 11'd0; cfg_y0 = 11'd0; cfg_w = 11'd64;
    cfg_fg = YELLOW; cfg_bg = BLUE; cfg_bg_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cfg_alpha = 9'($urandom_range(0, 300));
      frame_pulse();
      exp_q.delete();
      for (int i = 0; i < 30 + 3; i++) begin
        d = 16'($urandom);
        if (i < 30) begin
          exp_q.push_back({1'b1, d});
          drive(1'b1, 11'($urandom_range(0, 63)), 11'($urandom_range(0, 31)), d);
        end else begin
          exp_q.push_back(17'h0);
          drive(1'b0, 11'd0, 11'd0, 16'h0);
        end
        if (exp_q.size() == 3) begin
          e = exp_q.pop_front(); n_checks++;
          if ({out_de, out_data} !== e) begin
            n_err++;
            $display("FAIL transparent: got de=%0b data=%h want de=%0b data=%h", out_de, out_data, e[16], e[15:0]);
          end
        end
      end
    end
  endtask

  task automatic test_random_window();
    logic [16:0] e; logic [15:0] d; logic de; int x, y;
    for (int c = 0; c < 2048; c++) rom_mem[c] = $urandom;
    for (int k = 0; k < 4; k++) begin
      cfg_en = 1'b1; cfg_x0 = 11'($urandom_range(0, 2047)); cfg_y0 = 11'($urandom_range(0, 2047));
      cfg_w = 11'($urandom_range(1, SCROLL_LEN)); cfg_fg = 16'($urandom); cfg_bg = 16'($urandom);
      cfg_bg_en = 1'($urandom_range(0, 1)); cfg_alpha = 9'($urandom_range(0, 300));
      frame_pulse();
      exp_q.delete();
      for (int i = 0; i < 200 + 3; i++) begin
        de = (i < 200) && ($urandom_range(0, 7) != 0);
        x  = (int'(cfg_x0) + $urandom_range(0, int'(cfg_w) + 4) + 2046) % 2048;
        y  = (int'(cfg_y0) + $urandom_range(0, 35) + 2046) % 2048;
        d  = 16'($urandom);
        exp_q.push_back(ref_px(de, x, y, d));
        drive(de, 11'(x), 11'(y), d);
        if (exp_q.size() == 3) begin
          e = exp_q.pop_front(); n_checks++;
          if ({out_de, out_data} !== e) begin
            n_err++;
            $display("FAIL random_window: got de=%0b data=%h want de=%0b data=%h", out_de, out_data, e[16], e[15:0]);
          end
        end
      end
    end
  endtask

  task automatic test_shadow_alpha();
    logic [16:0] e; logic [15:0] d; int x, y;
    cfg_en = 1'b1; cfg_x0 = 11'd20; cfg_y0 = 11'd10; cfg_w = 11'd50;
    cfg_fg = WHITE; cfg_bg = BLACK; cfg_bg_en = 1'b1; cfg_alpha = 9'd0;
    for (int k = 0; k < 2; k++) begin
      frame_pulse();
      exp_q.delete();
      for (int i = 0; i < 40 + 3; i++) begin
        if (i == 20) begin cfg_alpha = 9'd256; cfg_fg = RED; end
        x = 20 + $urandom_range(0, 49); y = 10 + $urandom_range(0, 31); d = 16'($urandom);
        exp_q.push_back(ref_px(i < 40, x, y, d));
        drive(i < 40, 11'(x), 11'(y), d);
        if (exp_q.size() == 3) begin
          e = exp_q.pop_front(); n_checks++;
          if ({out_de, out_data} !== e) begin
            n_err++;
            $display("FAIL shadow_alpha frame%0d: got de=%0b data=%h want de=%0b data=%h", k, out_de, out_data, e[16], e[15:0]);
          end
        end
      end
    end
  endtask

  task automatic test_scroll_wrap();
    cfg_en = 1'b1; cfg_x0 = 11'd10; cfg_y0 = 11'd0; cfg_w = 11'd100; scroll_en = 1'b1;
    for (int p = 0; p < 2 * SCROLL_LEN; p++) begin
      frame_pulse();
      drive(1'b0, 11'd10, 11'd0, 16'h0);
      n_checks++;
      if (rom_addr !== 11'(m_offset())) begin
        n_err++;
        $display("FAIL scroll_offset pulse%0d: got %0d want %0d", p, rom_addr, m_offset());
      end
    end
    drive(1'b0, 11'd11, 11'd0, 16'h0);
    n_checks++;
    if (rom_addr !== 11'd0) begin n_err++; $display("FAIL scroll_wrap_col: got %0d want 0", rom_addr); end
    drive(1'b0, 11'd10, 11'd0, 16'h0);
    n_checks++;
    if (rom_addr !== 11'd1423) begin n_err++; $display("FAIL scroll_last: got %0d want 1423", rom_addr); end
    frame_pulse();
    drive(1'b0, 11'd10, 11'd0, 16'h0);
    n_checks++;
    if (rom_addr !== 11'd0) begin n_err++; $display("FAIL scroll_return0: got %0d want 0", rom_addr); end
    // Freeze: the pulse that captures scroll_en=0 still counts, then nothing moves.
    scroll_en = 1'b0;
    for (int p = 0; p < 5; p++) begin
      frame_pulse();
      drive(1'b0, 11'd10, 11'd0, 16'h0);
      n_checks++;
      if (rom_addr !== 11'(m_offset())) begin
        n_err++;
        $display("FAIL scroll_freeze pulse%0d: got %0d want %0d", p, rom_addr, m_offset());
      end
    end
  endtask

  task automatic test_reset_midline();
    logic [16:0] e; logic [15:0] d; int x, y;
    scroll_en = 1'b1; frame_pulse(); frame_pulse(); frame_pulse();
    cfg_en = 1'b1; cfg_x0 = 11'd0; cfg_y0 = 11'd0; cfg_w = 11'd1000;
    cfg_fg = YELLOW; cfg_bg = BLUE; cfg_bg_en = 1'b1; cfg_alpha = 9'd64; scroll_en = 1'b0;
    frame_pulse();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      x = $urandom_range(0, 999); y = $urandom_range(0, 31); d = 16'($urandom);
      exp_q.push_back(ref_px(1'b1, x, y, d));
      drive(1'b1, 11'(x), 11'(y), d);
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front(); n_checks++;
        if ({out_de, out_data} !== e) begin
          n_err++;
          $display("FAIL pre_reset: got de=%0b data=%h want de=%0b data=%h", out_de, out_data, e[16], e[15:0]);
        end
      end
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_de !== 1'b0) begin n_err++; $display("FAIL midline_reset_de: got %0b want 0", out_de); end
    n_checks++;
    if (out_data !== 16'h0) begin n_err++; $display("FAIL midline_reset_data: got %h want 0000", out_data); end
    tick();
    rst_n = 1'b1;
    m_en = 0; m_x0 = 0; m_y0 = 0; m_w = 0; m_fg = 0; m_bg = 0; m_bg_en = 0; m_alpha = 0;
    m_scroll_en = 0; m_counted = 0;
    drive(1'b0, 11'd5, 11'd0, 16'h0);
    n_checks++;
    if (rom_addr !== 11'd5) begin n_err++; $display("FAIL post_reset_offset: got %0d want 5", rom_addr); end
    exp_q.delete();
    for (int i = 0; i < 30 + 3; i++) begin
      x = $urandom_range(0, 999); y = $urandom_range(0, 31); d = 16'($urandom);
      exp_q.push_back((i < 30) ? {1'b1, d} : 17'h0);
      drive(i < 30, 11'(x), 11'(y), d);
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front(); n_checks++;
        if ({out_de, out_data} !== e) begin
          n_err++;
          $display("FAIL post_reset_passthru: got de=%0b data=%h want de=%0b data=%h", out_de, out_data, e[16], e[15:0]);
        end
      end
    end
    frame_pulse();
    exp_q.delete();
    for (int i = 0; i < 30 + 3; i++) begin
      x = $urandom_range(0, 999); y = $urandom_range(0, 31); d = 16'($urandom);
      exp_q.push_back(ref_px(i < 30, x, y, d));
      drive(i < 30, 11'(x), 11'(y), d);
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front(); n_checks++;
        if ({out_de, out_data} !== e) begin
          n_err++;
          $display("FAIL post_reset_overlay: got de=%0b data=%h want de=%0b data=%h", out_de, out_data, e[16], e[15:0]);
        end
      end
    end
  endtask

  initial begin
    for (int c = 0; c < 2048; c++) rom_mem[c] = 32'h0;
    test_reset();
    test_passthrough();
    test_opaque_glyph();
    test_blend();
    test_transparent();
    test_random_window();
    test_shadow_alpha();
    test_scroll_wrap();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
